// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge.
//   - Host command bytes ('W' write, 'R' read)
//   - Response bytes (ACK, NAK)
//   - Parser state enumeration used by uart_wb_bridge
package uart_pkg;

  // Host -> bridge command opcodes
  localparam logic [7:0] CmdWrite = 8'h57;  // 'W'
  localparam logic [7:0] CmdRead  = 8'h52;  // 'R'

  // Bridge -> host response codes
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspNak   = 8'h15;

  // Command parser states
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StResp
  } parser_state_e;

endpackage

// File: rtl/uart_serdes.sv
// 8N1 UART serializer/deserializer, LSB first.
// Ports:
//   i_CLK, i_RST  clock, synchronous active-high reset
//   i_RX          raw serial input (idle high), synchronized internally
//   o_TX          serial output (idle high), registered
//   rx_data       last received byte
//   rx_valid      rx_data holds a new byte; cleared when rx_ready is high
//   rx_ready      parser accepts the byte
//   rx_err        one-cycle pulse: byte received with stop bit low (discarded)
//   tx_data       byte to transmit
//   tx_valid      tx_data is valid
//   tx_ready      shifter accepts a byte this cycle
module uart_serdes #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_RX,
  output logic       o_TX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            rx_err_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_err_q  <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      unique case (rx_state_q)
        RxIdle: begin
          // Falling edge on the synchronized line starts a frame
          if (!rx_sync_q && rx_prev_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // A line back high at mid start bit was a glitch
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            if (rx_sync_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  // tx_bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  logic            tx_q;
  logic            tx_busy_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [8:0]      tx_shift_q;

  // Ready during the final stop-bit cycle so the next byte follows with no gap
  assign tx_ready = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == BitLast);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (tx_valid && tx_ready) begin
      tx_q       <= 1'b0;
      tx_shift_q <= {1'b1, tx_data};
      tx_busy_q  <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BitLast) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CntW'(1);
      end
    end
  end

  assign o_TX = tx_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-controlled Wishbone bus initiator.
// Host sends 'W' + 4 addr bytes + 4 data bytes, or 'R' + 4 addr bytes (big-endian).
// Bridge performs one bus transfer and replies: 0x06 (write ok), 4 data bytes
// MSB first (read ok) or 0x15 (unknown command or bus timeout).
// Ports:
//   i_CLK, i_RST   clock, synchronous active-high reset
//   i_RX, o_TX     8N1 serial link (idle high)
//   o_ADDR, o_DATA bus address / write data
//   i_DATA         bus read data
//   o_WE, o_SEL, o_STB, o_CYC, i_ACK  Wishbone control
//   o_BUSY         a command is in progress
module uart_wb_bridge
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT      = 1250,
  parameter int unsigned WB_TIMEOUT        = 255,
  parameter int unsigned IDLE_TIMEOUT_BITS = 160
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_RX,
  output logic        o_TX,
  output logic [31:0] o_ADDR,
  output logic [31:0] o_DATA,
  input  logic [31:0] i_DATA,
  output logic        o_WE,
  output logic [3:0]  o_SEL,
  output logic        o_STB,
  output logic        o_CYC,
  input  logic        i_ACK,
  output logic        o_BUSY
);

  localparam int unsigned IdleLimit = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] tx_data;
  logic       tx_ready;

  parser_state_e state_q;
  logic          is_write_q;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   resp_buf_q;
  logic [2:0]    resp_left_q;
  logic          tx_valid_q;
  logic [31:0]   idle_cnt_q;
  logic [31:0]   wb_cnt_q;
  logic          cyc_q, stb_q, we_q;
  logic [3:0]    sel_q;

  // Parser always accepts; bytes arriving in BUS/RESP are simply dropped.
  uart_serdes #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serdes (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_RX    (i_RX),
    .o_TX    (o_TX),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(1'b1),
    .rx_err  (rx_err),
    .tx_data (tx_data),
    .tx_valid(tx_valid_q),
    .tx_ready(tx_ready)
  );

  // Response bytes leave from the top of resp_buf_q
  assign tx_data = resp_buf_q[31:24];

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_buf_q  <= '0;
      resp_left_q <= '0;
      tx_valid_q  <= 1'b0;
      idle_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idle_cnt_q <= '0;
          if (rx_valid) begin
            if (rx_data == CmdWrite || rx_data == CmdRead) begin
              is_write_q <= (rx_data == CmdWrite);
              byte_cnt_q <= '0;
              state_q    <= StAddr;
            end else begin
              resp_buf_q  <= {RspNak, 24'h0};
              resp_left_q <= 3'd1;
              tx_valid_q  <= 1'b1;
              state_q     <= StResp;
            end
          end
        end

        StAddr, StData: begin
          if (rx_err) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            idle_cnt_q <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;  // wraps to 0 after the 4th byte
            if (state_q == StAddr) addr_q  <= {addr_q[23:0], rx_data};
            else                   wdata_q <= {wdata_q[23:0], rx_data};
            if (byte_cnt_q == 2'd3) begin
              if (state_q == StAddr && is_write_q) begin
                state_q <= StData;
              end else begin
                state_q  <= StBus;
                cyc_q    <= 1'b1;
                stb_q    <= 1'b1;
                sel_q    <= 4'hF;
                we_q     <= is_write_q;
                wb_cnt_q <= '0;
              end
            end
          end else if (idle_cnt_q == IdleLimit - 1) begin
            state_q <= StIdle;  // host went quiet mid-command
          end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
          end
        end

        StBus: begin
          if (i_ACK && stb_q) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= StResp;
            if (is_write_q) begin
              resp_buf_q  <= {RspAck, 24'h0};
              resp_left_q <= 3'd1;
            end else begin
              resp_buf_q  <= i_DATA;
              resp_left_q <= 3'd4;
            end
          end else if (wb_cnt_q == WB_TIMEOUT - 1) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            resp_buf_q  <= {RspNak, 24'h0};
            resp_left_q <= 3'd1;
            tx_valid_q  <= 1'b1;
            state_q     <= StResp;
          end else begin
            wb_cnt_q <= wb_cnt_q + 32'd1;
          end
        end

        StResp: begin
          if (tx_valid_q && tx_ready) begin
            resp_buf_q  <= {resp_buf_q[23:0], 8'h00};
            resp_left_q <= resp_left_q - 3'd1;
            if (resp_left_q == 3'd1) begin
              tx_valid_q <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ADDR = addr_q;
  assign o_DATA = wdata_q;
  assign o_WE   = we_q;
  assign o_SEL  = sel_q;
  assign o_STB  = stb_q;
  assign o_CYC  = cyc_q;
  assign o_BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed self-checking bench for uart_wb_bridge with a command-level model.
module tb_uart_wb_bridge;

  localparam int unsigned CPB = 16;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_RX  = 1'b1;
  logic        o_TX;
  logic [31:0] o_ADDR, o_DATA;
  logic [31:0] i_DATA = 32'h0;
  logic        o_WE;
  logic [3:0]  o_SEL;
  logic        o_STB, o_CYC;
  logic        i_ACK = 1'b0;
  logic        o_BUSY;

  always #5 i_CLK = ~i_CLK;

  uart_wb_bridge #(
    .CLKS_PER_BIT     (CPB),
    .WB_TIMEOUT       (255),
    .IDLE_TIMEOUT_BITS(160)
  ) dut (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_RX  (i_RX),
    .o_TX  (o_TX),
    .o_ADDR(o_ADDR),
    .o_DATA(o_DATA),
    .i_DATA(i_DATA),
    .o_WE  (o_WE),
    .o_SEL (o_SEL),
    .o_STB (o_STB),
    .o_CYC (o_CYC),
    .i_ACK (i_ACK),
    .o_BUSY(o_BUSY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  int unsigned cyc_n = 0;
  always @(posedge i_CLK) cyc_n <= cyc_n + 1;

  // Command-level model state
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_tx[$];
  logic        exp_bus = 1'b0;
  logic        exp_we  = 1'b0;
  logic [31:0] exp_addr = '0, exp_data = '0;

  // Slave controls and records (slave process is the only writer of records)
  int          ack_delay = -1;
  logic [31:0] slave_rdata = '0;
  int          stray_cnt = 0;
  int          stray_done = 0;
  int          wait_cnt = 0;
  int          xfer_total = 0;
  logic [31:0] xfer_addr = '0, xfer_data = '0;
  logic        xfer_we = 1'b0;
  logic [3:0]  xfer_sel = '0;

  // TX monitor records (monitor is the only writer)
  logic [7:0]  got_tx[$];
  int unsigned got_t[$];

  // Bus monitor records
  int unsigned cyc_len = 0;
  int unsigned last_cyc_len = 0;

  // Expected behaviour of one host command from the protocol rules.
  task automatic model_cmd(input int delay, input logic [31:0] rdata);
    int need;
    exp_tx.delete();
    exp_bus  = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    if (cmd_q.size() == 0) return;
    if (cmd_q[0] != 8'h57 && cmd_q[0] != 8'h52) begin
      exp_tx.push_back(8'h15);
      return;
    end
    exp_we = (cmd_q[0] == 8'h57);
    need   = exp_we ? 9 : 5;
    if (cmd_q.size() < need) return;  // incomplete: silent abandon
    for (int i = 1; i <= 4; i++) exp_addr = {exp_addr[23:0], cmd_q[i]};
    if (exp_we) for (int i = 5; i <= 8; i++) exp_data = {exp_data[23:0], cmd_q[i]};
    exp_bus = 1'b1;
    if (delay < 0)   exp_tx.push_back(8'h15);
    else if (exp_we) exp_tx.push_back(8'h06);
    else for (int k = 3; k >= 0; k--) exp_tx.push_back(rdata[8*k +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    @(negedge i_CLK);
    i_RX = 1'b0;
    repeat (CPB) @(negedge i_CLK);
    for (int i = 0; i < 8; i++) begin
      i_RX = b[i];
      repeat (CPB) @(negedge i_CLK);
    end
    i_RX = stop_val;
    repeat (CPB) @(negedge i_CLK);
    i_RX = 1'b1;
  endtask

  function automatic logic [7:0] last_tx(input int k);
    int idx;
    idx = got_tx.size() - 1 - k;
    if (idx < 0) return 8'hxx;
    return got_tx[idx];
  endfunction

  int run_wait;

  task automatic run_cmd(input string name, input int delay, input logic [31:0] rdata,
                         input int budget);
    int base, xbase, n;
    model_cmd(delay, rdata);
    ack_delay   = delay;
    slave_rdata = rdata;
    base  = got_tx.size();
    xbase = xfer_total;
    foreach (cmd_q[i]) send_byte(cmd_q[i], 1'b1);
    n = 0;
    while (((got_tx.size() - base) < exp_tx.size() || o_BUSY) && n < budget) begin
      @(negedge i_CLK);
      n++;
    end
    run_wait = n;
    check({name, "_finished_in_budget"}, 32'(n < budget), 32'd1);
    repeat (200) @(negedge i_CLK);
    check({name, "_tx_count"}, 32'(got_tx.size() - base), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (base + i < got_tx.size()) begin
        check({name, "_tx_byte"}, 32'(got_tx[base+i]), 32'(exp_tx[i]));
        if (i > 0)
          check({name, "_tx_spacing"}, got_t[base+i] - got_t[base+i-1], 32'd160);
      end
    end
    check({name, "_xfers"}, 32'(xfer_total - xbase), 32'((exp_bus && delay >= 0) ? 1 : 0));
    check({name, "_busy_end"}, 32'(o_BUSY), 32'd0);
  endtask

  // Wishbone slave: ack after ack_delay cycles of o_CYC&o_STB, or stray ack on request
  initial begin
    forever begin
      @(negedge i_CLK);
      if (i_ACK) begin
        i_ACK = 1'b0;
      end else if (stray_done != stray_cnt) begin
        stray_done = stray_cnt;
        i_ACK  = 1'b1;
        i_DATA = 32'hBAD0BAD0;
      end else if (o_CYC && o_STB && !i_RST) begin
        wait_cnt++;
        if (ack_delay >= 0 && wait_cnt == ack_delay) begin
          i_ACK     = 1'b1;
          i_DATA    = slave_rdata;
          xfer_total++;
          xfer_addr = o_ADDR;
          xfer_data = o_DATA;
          xfer_we   = o_WE;
          xfer_sel  = o_SEL;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Bus compare: every cycle with o_CYC high must match the model's transfer
  initial begin
    forever begin
      @(negedge i_CLK);
      if (!i_RST) begin
        if (o_CYC) begin
          cyc_len++;
          check("cyc_vs_model", 32'(o_CYC), 32'(exp_bus));
          check("bus_stb", 32'(o_STB), 32'd1);
          check("bus_sel", 32'(o_SEL), 32'hF);
          check("bus_addr", o_ADDR, exp_addr);
          check("bus_we", 32'(o_WE), 32'(exp_we));
          if (exp_we) check("bus_wdata", o_DATA, exp_data);
        end else begin
          if (cyc_len != 0) last_cyc_len = cyc_len;
          cyc_len = 0;
        end
      end else begin
        cyc_len = 0;
      end
    end
  end

  // TX decoder
  initial begin
    logic [7:0] b;
    int unsigned t;
    forever begin
      @(negedge i_CLK);
      if (o_TX === 1'b0 && !i_RST) begin
        t = cyc_n;
        repeat (CPB / 2) @(negedge i_CLK);
        check("tx_start_bit", 32'(o_TX), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge i_CLK);
          b[i] = o_TX;
        end
        repeat (CPB) @(negedge i_CLK);
        check("tx_stop_bit", 32'(o_TX), 32'd1);
        got_tx.push_back(b);
        got_t.push_back(t);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", n_checks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    // Reset values
    repeat (4) @(negedge i_CLK);
    check("rst_tx", 32'(o_TX), 32'd1);
    check("rst_cyc", 32'(o_CYC), 32'd0);
    check("rst_stb", 32'(o_STB), 32'd0);
    check("rst_we", 32'(o_WE), 32'd0);
    check("rst_sel", 32'(o_SEL), 32'd0);
    check("rst_addr", o_ADDR, 32'd0);
    check("rst_data", o_DATA, 32'd0);
    check("rst_busy", 32'(o_BUSY), 32'd0);
    i_RST = 1'b0;
    repeat (20) @(negedge i_CLK);

    // Write, ack after 3 cycles
    cmd_q = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_cmd("write", 3, 32'h0, 4000);
    check("write_addr_lit", xfer_addr, 32'h00001004);
    check("write_data_lit", xfer_data, 32'hDEADBEEF);
    check("write_we_lit", 32'(xfer_we), 32'd1);
    check("write_sel_lit", 32'(xfer_sel), 32'hF);
    check("write_resp_lit", 32'(last_tx(0)), 32'h06);

    // Read returning 0x12345678
    cmd_q = '{8'h52, 8'h00, 8'h00, 8'h20, 8'h00};
    run_cmd("read", 2, 32'h12345678, 4000);
    check("read_addr_lit", xfer_addr, 32'h00002000);
    check("read_we_lit", 32'(xfer_we), 32'd0);
    check("read_b0_lit", 32'(last_tx(3)), 32'h12);
    check("read_b1_lit", 32'(last_tx(2)), 32'h34);
    check("read_b2_lit", 32'(last_tx(1)), 32'h56);
    check("read_b3_lit", 32'(last_tx(0)), 32'h78);

    // Read with no ack: bus timeout then NAK
    cmd_q = '{8'h52, 8'h00, 8'h00, 8'h30, 8'h00};
    run_cmd("wbto", -1, 32'h0, 4000);
    check("wbto_cyc_len_lit", last_cyc_len, 32'd255);
    check("wbto_resp_lit", 32'(last_tx(0)), 32'h15);

    // Stray ack while idle has no effect
    stray_cnt++;
    repeat (5) @(negedge i_CLK);
    check("stray_busy", 32'(o_BUSY), 32'd0);
    check("stray_cyc", 32'(o_CYC), 32'd0);

    // Unknown command byte
    cmd_q = '{8'h41};
    run_cmd("badcmd", 3, 32'h0, 4000);
    check("badcmd_resp_lit", 32'(last_tx(0)), 32'h15);

    // Partial command then silence: idle timeout ~160 bit times after last byte
    cmd_q = '{8'h57, 8'h00};
    run_cmd("idleto", 3, 32'h0, 4000);
    check("idleto_window", 32'(run_wait > 2400 && run_wait < 2700), 32'd1);

    // Framing error byte, then a valid read
    send_byte(8'hA5, 1'b0);
    repeat (32) @(negedge i_CLK);
    check("frame_busy", 32'(o_BUSY), 32'd0);
    cmd_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h44};
    run_cmd("frame_read", 1, 32'hCAFEF00D, 4000);
    check("frame_read_b0_lit", 32'(last_tx(3)), 32'hCA);
    check("frame_read_b3_lit", 32'(last_tx(0)), 32'h0D);

    // Reset during a bus cycle
    cmd_q = '{8'h52, 8'h00, 8'h00, 8'h40, 8'h00};
    model_cmd(-1, 32'h0);
    ack_delay = -1;
    base = got_tx.size();
    foreach (cmd_q[i]) send_byte(cmd_q[i], 1'b1);
    n = 0;
    while (!o_CYC && n < 200) begin
      @(negedge i_CLK);
      n++;
    end
    check("rstbus_cyc_seen", 32'(o_CYC), 32'd1);
    repeat (10) @(negedge i_CLK);
    i_RST = 1'b1;
    @(negedge i_CLK);
    check("rstbus_cyc", 32'(o_CYC), 32'd0);
    check("rstbus_stb", 32'(o_STB), 32'd0);
    check("rstbus_tx", 32'(o_TX), 32'd1);
    check("rstbus_busy", 32'(o_BUSY), 32'd0);
    i_RST = 1'b0;
    repeat (400) @(negedge i_CLK);
    check("rstbus_no_tx", 32'(got_tx.size() - base), 32'd0);

    // Write after reset
    cmd_q = '{8'h57, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01};
    run_cmd("write2", 1, 32'h0, 4000);
    check("write2_addr_lit", xfer_addr, 32'h12345678);
    check("write2_data_lit", xfer_data, 32'h00000001);
    check("write2_resp_lit", 32'(last_tx(0)), 32'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
